// File: rtl/cpu_state_monitor_pkg.sv
// Shared encodings for the CPU architectural-state monitor: FSM states and
// probe-select codes.
package cpu_state_monitor_pkg;

  typedef enum logic [1:0] {
    STATE_RUN     = 2'd0,
    STATE_HALTED  = 2'd1,
    STATE_TIMEOUT = 2'd2
  } state_e;

  localparam logic [1:0] PROBE_GPR = 2'd0;
  localparam logic [1:0] PROBE_HI  = 2'd1;
  localparam logic [1:0] PROBE_LO  = 2'd2;

endpackage

// File: rtl/monitor_shadow_file.sv
// Shadow GPR storage: one write port, one registered read port.
// Entry 0 is hardwired to zero; clear and reset wipe every entry.
module monitor_shadow_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0] read_data
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic [DATA_WIDTH-1:0]            read_data_q, read_data_d;

  always_comb begin
    mem_d       = mem_q;
    // Read from the pre-write contents so a same-cycle write is not visible yet.
    read_data_d = mem_q[read_address];
    if (clear) begin
      mem_d       = '0;
      read_data_d = '0;
    end else if (write_enable) begin
      mem_d[write_address] = write_data;
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q       <= '0;
      read_data_q <= '0;
    end else begin
      mem_q       <= mem_d;
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;

endmodule

// File: rtl/cpu_state_monitor.sv
// Architectural-state monitor: shadow GPR/HI/LO, cycle/write counters, halt and
// timeout detection, registered probe. CPU_STATE_MONITOR_SIGNATURE_EN adds a write signature.
module cpu_state_monitor
  import cpu_state_monitor_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 5,
  parameter int                    TIMEOUT_CYCLES = 1000,
  parameter logic [DATA_WIDTH-1:0] HALT_PC        = DATA_WIDTH'(32'hFFFF_FFFC),
  parameter int                    COUNT_WIDTH    = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   register_write_enable,
  input  logic [ADDR_WIDTH-1:0]  register_write_address,
  input  logic [DATA_WIDTH-1:0]  register_write_data,
  input  logic                   register_hi_write_enable,
  input  logic [DATA_WIDTH-1:0]  register_hi_write_data,
  input  logic                   register_lo_write_enable,
  input  logic [DATA_WIDTH-1:0]  register_lo_write_data,
  input  logic [DATA_WIDTH-1:0]  instruction_address,
  input  logic [1:0]             probe_select,
  input  logic [ADDR_WIDTH-1:0]  probe_address,
  output logic [DATA_WIDTH-1:0]  probe_data,
  output logic [COUNT_WIDTH-1:0] cycle_count,
  output logic [COUNT_WIDTH-1:0] write_count,
  output logic                   halted,
  output logic                   timed_out,
  output logic [DATA_WIDTH-1:0]  signature
);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cycle_q, cycle_d, wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d, hilo_probe_q, hilo_probe_d;
  logic [1:0]             sel_q, sel_d;
  logic                   run, gpr_acc, hi_acc, lo_acc;
  logic [1:0]             inc;
  logic [COUNT_WIDTH:0]   wsum;
  logic [DATA_WIDTH-1:0]  gpr_rd;

  always_comb begin
    run     = (state_q == STATE_RUN);
    gpr_acc = run && register_write_enable && (register_write_address != '0);
    hi_acc  = run && register_hi_write_enable;
    lo_acc  = run && register_lo_write_enable;
    inc     = {1'b0, gpr_acc} + {1'b0, hi_acc} + {1'b0, lo_acc};
    wsum    = {1'b0, wcnt_q} + {{(COUNT_WIDTH-1){1'b0}}, inc};

    state_d = state_q;
    if (run) begin
      // Halt match outranks a timeout landing on the same cycle.
      if (instruction_address == HALT_PC)
        state_d = STATE_HALTED;
      else if (cycle_q == COUNT_WIDTH'(TIMEOUT_CYCLES - 1))
        state_d = STATE_TIMEOUT;
    end

    cycle_d = run ? cycle_q + COUNT_WIDTH'(1) : cycle_q;
    wcnt_d  = wsum[COUNT_WIDTH] ? '1 : wsum[COUNT_WIDTH-1:0];
    hi_d    = hi_acc ? register_hi_write_data : hi_q;
    lo_d    = lo_acc ? register_lo_write_data : lo_q;
    sel_d   = probe_select;
    case (probe_select)
      PROBE_HI: hilo_probe_d = hi_q;
      PROBE_LO: hilo_probe_d = lo_q;
      default:  hilo_probe_d = '0;
    endcase

    if (clear) begin
      state_d      = STATE_RUN;
      cycle_d      = '0;
      wcnt_d       = '0;
      hi_d         = '0;
      lo_d         = '0;
      sel_d        = PROBE_GPR;
      hilo_probe_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= STATE_RUN;
      cycle_q      <= '0;
      wcnt_q       <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      sel_q        <= PROBE_GPR;
      hilo_probe_q <= '0;
    end else begin
      state_q      <= state_d;
      cycle_q      <= cycle_d;
      wcnt_q       <= wcnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      sel_q        <= sel_d;
      hilo_probe_q <= hilo_probe_d;
    end
  end

  monitor_shadow_file #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_shadow (
    .clock         (clock),
    .reset         (reset),
    .clear         (clear),
    .write_enable  (gpr_acc),
    .write_address (register_write_address),
    .write_data    (register_write_data),
    .read_address  (probe_address),
    .read_data     (gpr_rd)
  );

`ifdef CPU_STATE_MONITOR_SIGNATURE_EN
  logic [DATA_WIDTH-1:0] sig_q, sig_d;

  function automatic logic [DATA_WIDTH-1:0] sig_step(input logic [DATA_WIDTH-1:0] s,
                                                     input logic [DATA_WIDTH-1:0] d,
                                                     input logic [DATA_WIDTH-1:0] a);
    return {s[DATA_WIDTH-2:0], s[DATA_WIDTH-1]} ^ d ^ a;
  endfunction

  // Folded in the fixed order GPR, HI, LO; HI/LO use the addresses just past the GPR file.
  always_comb begin
    sig_d = sig_q;
    if (gpr_acc) sig_d = sig_step(sig_d, register_write_data, DATA_WIDTH'(register_write_address));
    if (hi_acc)  sig_d = sig_step(sig_d, register_hi_write_data, DATA_WIDTH'(2**ADDR_WIDTH));
    if (lo_acc)  sig_d = sig_step(sig_d, register_lo_write_data, DATA_WIDTH'(2**ADDR_WIDTH + 1));
    if (clear)   sig_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sig_q <= '0;
    else       sig_q <= sig_d;
  end

  assign signature = sig_q;
`else
  assign signature = '0;
`endif

  assign probe_data  = (sel_q == PROBE_GPR) ? gpr_rd : hilo_probe_q;
  assign cycle_count = cycle_q;
  assign write_count = wcnt_q;
  assign halted      = (state_q == STATE_HALTED);
  assign timed_out   = (state_q == STATE_TIMEOUT);

endmodule

// File: tb/tb_cpu_state_monitor.sv
// Self-checking bench for cpu_state_monitor; probe results go through a
// due-cycle scoreboard, counters and flags are checked inline per scenario.
module tb_cpu_state_monitor;

  localparam logic [31:0] HALT = 32'hFFFF_FFFC;

  logic        clock = 1'b0;
  logic        reset, clear;
  logic        register_write_enable, register_hi_write_enable, register_lo_write_enable;
  logic [4:0]  register_write_address, probe_address;
  logic [31:0] register_write_data, register_hi_write_data, register_lo_write_data;
  logic [31:0] instruction_address, probe_data, cycle_count, write_count, signature;
  logic [1:0]  probe_select;
  logic        halted, timed_out;

  cpu_state_monitor #(.TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .register_write_enable(register_write_enable),
    .register_write_address(register_write_address),
    .register_write_data(register_write_data),
    .register_hi_write_enable(register_hi_write_enable),
    .register_hi_write_data(register_hi_write_data),
    .register_lo_write_enable(register_lo_write_enable),
    .register_lo_write_data(register_lo_write_data),
    .instruction_address(instruction_address),
    .probe_select(probe_select), .probe_address(probe_address),
    .probe_data(probe_data), .cycle_count(cycle_count), .write_count(write_count),
    .halted(halted), .timed_out(timed_out), .signature(signature)
  );

  always #5 clock = ~clock;

  typedef struct {int due; logic [31:0] exp;} sb_t;
  sb_t sb[$];
  sb_t head;
  int  checks = 0, errors = 0, cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Probe results are compared mid-cycle after the edge that sampled the request.
  always @(negedge clock) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      head = sb.pop_front();
      checks++;
      if (probe_data !== head.exp) begin
        errors++;
        $display("FAIL probe: got %h expected %h (cycle %0d)", probe_data, head.exp, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    clear = 1'b0;
    register_write_enable = 1'b0; register_write_address = '0; register_write_data = '0;
    register_hi_write_enable = 1'b0; register_hi_write_data = '0;
    register_lo_write_enable = 1'b0; register_lo_write_data = '0;
    instruction_address = '0;
  endtask

  task automatic probe(input logic [1:0] s, input logic [4:0] a, input logic [31:0] e);
    probe_select = s;
    probe_address = a;
    sb.push_back('{cyc + 1, e});
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic write_gpr(input logic [4:0] a, input logic [31:0] d);
    register_write_enable = 1'b1; register_write_address = a; register_write_data = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; probe_select = 2'd0; probe_address = '0;
    drive_idle();
    tick();
    checks++; if ({halted, timed_out} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {halted, timed_out}); end
    checks++; if (cycle_count !== 0 || write_count !== 0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", cycle_count, write_count); end
    checks++; if (probe_data !== 0 || signature !== 0) begin errors++; $display("FAIL reset_data: got %h/%h expected 0/0", probe_data, signature); end
    @(negedge clock); reset = 1'b0;
    tick();
    checks++; if (cycle_count !== 1) begin errors++; $display("FAIL reset_run: got %0d expected 1", cycle_count); end
  endtask

  task automatic test_gpr_write();
    do_clear();
    write_gpr(5'd3, 32'h0000_1234); tick();
    write_gpr(5'd0, 32'hFFFF_FFFF); tick();
    register_write_enable = 1'b0;
    checks++; if (write_count !== 1) begin errors++; $display("FAIL gpr0_discard: got %0d expected 1", write_count); end
`ifdef CPU_STATE_MONITOR_SIGNATURE_EN
    checks++; if (signature !== 32'h0000_1237) begin errors++; $display("FAIL gpr_sig: got %h expected 00001237", signature); end
`else
    checks++; if (signature !== 0) begin errors++; $display("FAIL gpr_sig: got %h expected 0", signature); end
`endif
    probe(2'd0, 5'd3, 32'h0000_1234); tick();
    probe(2'd0, 5'd0, 32'h0); tick();
    tick();
  endtask

  task automatic test_same_cycle();
    do_clear();
    write_gpr(5'd5, 32'hA);
    register_hi_write_enable = 1'b1; register_hi_write_data = 32'hB;
    register_lo_write_enable = 1'b1; register_lo_write_data = 32'hC;
    tick();
    drive_idle();
    checks++; if (write_count !== 3) begin errors++; $display("FAIL same_cycle_count: got %0d expected 3", write_count); end
    probe(2'd0, 5'd5, 32'hA); tick();
    probe(2'd1, 5'd0, 32'hB); tick();
    probe(2'd2, 5'd0, 32'hC); tick();
    probe(2'd3, 5'd5, 32'h0); tick();
    tick();
  endtask

  task automatic test_read_before_write();
    do_clear();
    write_gpr(5'd4, 32'h1); tick();
    write_gpr(5'd4, 32'h2); probe(2'd0, 5'd4, 32'h1); tick();
    register_write_enable = 1'b0; probe(2'd0, 5'd4, 32'h2); tick();
    register_hi_write_enable = 1'b1; register_hi_write_data = 32'h7; tick();
    register_hi_write_data = 32'h8; probe(2'd1, 5'd0, 32'h7); tick();
    register_hi_write_enable = 1'b0; probe(2'd1, 5'd0, 32'h8); tick();
    tick();
    checks++; if (write_count !== 4) begin errors++; $display("FAIL rbw_count: got %0d expected 4", write_count); end
  endtask

  task automatic test_halt();
    do_clear();
    write_gpr(5'd2, 32'h77); tick();
    register_write_enable = 1'b0;
    repeat (6) tick();
    instruction_address = HALT; tick();
    checks++; if ({halted, timed_out} !== 2'b10) begin errors++; $display("FAIL halt_flags: got %b expected 10", {halted, timed_out}); end
    checks++; if (cycle_count !== 8) begin errors++; $display("FAIL halt_cycle: got %0d expected 8", cycle_count); end
    instruction_address = '0;
    write_gpr(5'd6, 32'h55);
    register_hi_write_enable = 1'b1; register_hi_write_data = 32'h99;
    tick();
    drive_idle(); tick();
    checks++; if (cycle_count !== 8 || write_count !== 1) begin errors++; $display("FAIL halt_frozen: got %0d/%0d expected 8/1", cycle_count, write_count); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b expected 1", halted); end
    probe(2'd0, 5'd6, 32'h0); tick();
    probe(2'd1, 5'd0, 32'h0); tick();
    probe(2'd0, 5'd2, 32'h77); tick();
    tick();
  endtask

  task automatic test_clear_after_halt();
    do_clear();
    checks++; if ({halted, timed_out} !== 2'b00 || cycle_count !== 0 || write_count !== 0) begin
      errors++; $display("FAIL clear_state: got %b %0d %0d expected 00 0 0", {halted, timed_out}, cycle_count, write_count); end
    checks++; if (probe_data !== 0 || signature !== 0) begin errors++; $display("FAIL clear_data: got %h/%h expected 0/0", probe_data, signature); end
    tick();
    checks++; if (cycle_count !== 1) begin errors++; $display("FAIL clear_run: got %0d expected 1", cycle_count); end
    probe(2'd0, 5'd2, 32'h0); tick();
    tick();
  endtask

  task automatic test_timeout();
    do_clear();
    repeat (15) tick();
    checks++; if (timed_out !== 1'b0 || cycle_count !== 15) begin errors++; $display("FAIL timeout_early: got %b/%0d expected 0/15", timed_out, cycle_count); end
    tick();
    checks++; if ({halted, timed_out} !== 2'b01 || cycle_count !== 16) begin errors++; $display("FAIL timeout_hit: got %b/%0d expected 01/16", {halted, timed_out}, cycle_count); end
    instruction_address = HALT; write_gpr(5'd9, 32'h5); tick();
    drive_idle(); tick();
    checks++; if ({halted, timed_out} !== 2'b01 || write_count !== 0 || cycle_count !== 16) begin
      errors++; $display("FAIL timeout_sticky: got %b %0d %0d expected 01 0 16", {halted, timed_out}, write_count, cycle_count); end
    // Halt match on the last RUN cycle must beat the timeout.
    do_clear();
    repeat (15) tick();
    instruction_address = HALT; tick();
    instruction_address = '0;
    checks++; if ({halted, timed_out} !== 2'b10 || cycle_count !== 16) begin errors++; $display("FAIL halt_wins: got %b/%0d expected 10/16", {halted, timed_out}, cycle_count); end
  endtask

  task automatic test_async_reset();
    do_clear();
    write_gpr(5'd7, 32'h33); tick();
    register_write_enable = 1'b0;
    probe(2'd0, 5'd7, 32'h33); instruction_address = HALT; tick();
    instruction_address = '0;
    @(negedge clock); #1;
    reset = 1'b1; #1;
    checks++; if ({halted, timed_out} !== 2'b00 || cycle_count !== 0 || write_count !== 0) begin
      errors++; $display("FAIL async_state: got %b %0d %0d expected 00 0 0", {halted, timed_out}, cycle_count, write_count); end
    checks++; if (probe_data !== 0 || signature !== 0) begin errors++; $display("FAIL async_data: got %h/%h expected 0/0", probe_data, signature); end
    tick();
    @(negedge clock); reset = 1'b0;
    tick();
    probe(2'd0, 5'd7, 32'h0); tick();
    tick();
  endtask

  task automatic test_signature();
    reset = 1'b1; tick();
    @(negedge clock); reset = 1'b0;
    tick();
    write_gpr(5'd1, 32'h1); tick();
    register_write_enable = 1'b0;
    checks++; if (signature !== 0) begin errors++; $display("FAIL sig_gpr1: got %h expected 0", signature); end
    register_hi_write_enable = 1'b1; register_hi_write_data = 32'h10; tick();
    register_hi_write_enable = 1'b0;
    register_lo_write_enable = 1'b1; register_lo_write_data = 32'h5; tick();
    drive_idle();
`ifdef CPU_STATE_MONITOR_SIGNATURE_EN
    checks++; if (signature !== 32'h44) begin errors++; $display("FAIL sig_hilo: got %h expected 00000044", signature); end
`else
    checks++; if (signature !== 0) begin errors++; $display("FAIL sig_hilo: got %h expected 0", signature); end
`endif
    checks++; if (write_count !== 3) begin errors++; $display("FAIL sig_count: got %0d expected 3", write_count); end
  endtask

  initial begin
    test_reset();
    test_gpr_write();
    test_same_cycle();
    test_read_before_write();
    test_halt();
    test_clear_after_halt();
    test_timeout();
    test_async_reset();
    test_signature();
    repeat (3) tick();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
